// File: rtl/line_window_ctrl.sv
// ---------------------------------------------------------------------------
// line_window_ctrl
//   Buffers an incoming raster pixel stream in four rotating line buffers and
//   emits one 3x3 window per output pixel for the downstream convolution
//   kernels. o_intr pulses with the last window of every output line, which
//   frees one line buffer so the host may send the next line.
//
// Ports
//   i_clk               single clock
//   i_rst_n             asynchronous active-low reset
//   i_pixel_data        input pixel, raster order
//   i_pixel_data_valid  i_pixel_data valid this cycle
//   o_pixel_data        3x3 window; [8*(3*r+k) +: 8] = row r, column k
//                       (row 0 is the oldest line)
//   o_pixel_data_valid  o_pixel_data valid this cycle
//   o_intr              one-cycle pulse with the last window of a line
// ---------------------------------------------------------------------------
module line_window_ctrl #(
  parameter int IMG_WIDTH = 3840,
  parameter int DATA_W    = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [DATA_W-1:0]     i_pixel_data,
  input  logic                  i_pixel_data_valid,
  output logic [9*DATA_W-1:0]   o_pixel_data,
  output logic                  o_pixel_data_valid,
  output logic                  o_intr
);

  localparam int PIX_W = $clog2(IMG_WIDTH);
  localparam int CNT_W = $clog2(4*IMG_WIDTH + 1);

  localparam logic [PIX_W-1:0] PIX_LAST  = PIX_W'(IMG_WIDTH - 1);
  localparam logic [PIX_W-1:0] PIX_ONE   = PIX_W'(1);
  localparam logic [PIX_W-1:0] PIX_TWO   = PIX_W'(2);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(4*IMG_WIDTH);
  localparam logic [CNT_W-1:0] CNT_READY = CNT_W'(3*IMG_WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } state_t;

  state_t state_reg, state_next;

  logic [PIX_W-1:0] wr_pix_reg;
  logic [1:0]       wr_sel_reg;
  logic [PIX_W-1:0] rd_pix_reg;
  logic [1:0]       rd_sel_reg;
  logic [CNT_W-1:0] total_cnt_reg, total_cnt_next;
  logic             ready_reg;

  logic wr_en;
  logic rd_en;

  // Four line buffers; contents are never cleared.
  logic [DATA_W-1:0] lb [4][IMG_WIDTH];

  logic [PIX_W-1:0]   col_idx [3];
  logic [1:0]         row_idx [3];
  logic [9*DATA_W-1:0] window_next;

  // -------------------------------------------------------------------------
  // Write side: the occupancy count gates every write, so the writer can never
  // overwrite row-0 data that has not been read yet.
  // -------------------------------------------------------------------------
  assign wr_en = i_pixel_data_valid && (total_cnt_reg < CNT_FULL);

  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      lb[wr_sel_reg][wr_pix_reg] <= i_pixel_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_pix_reg <= '0;
      wr_sel_reg <= '0;
    end else if (wr_en) begin
      if (wr_pix_reg == PIX_LAST) begin
        wr_pix_reg <= '0;
        wr_sel_reg <= wr_sel_reg + 2'd1;
      end else begin
        wr_pix_reg <= wr_pix_reg + PIX_ONE;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Occupancy counter and registered "three lines available" flag
  // -------------------------------------------------------------------------
  always_comb begin
    total_cnt_next = total_cnt_reg;
    case ({wr_en, rd_en})
      2'b10:   total_cnt_next = total_cnt_reg + CNT_ONE;
      2'b01:   total_cnt_next = total_cnt_reg - CNT_ONE;
      default: total_cnt_next = total_cnt_reg;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      total_cnt_reg <= '0;
      ready_reg     <= 1'b0;
    end else begin
      total_cnt_reg <= total_cnt_next;
      ready_reg     <= (total_cnt_next >= CNT_READY);
    end
  end

  // -------------------------------------------------------------------------
  // Read FSM: one full line per READ visit, then back through IDLE, which
  // guarantees a gap cycle between output lines.
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    rd_en      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (ready_reg) begin
          state_next = READ;
        end
      end
      READ: begin
        rd_en = 1'b1;
        if (rd_pix_reg == PIX_LAST) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg  <= IDLE;
      rd_pix_reg <= '0;
      rd_sel_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (rd_en) begin
        if (rd_pix_reg == PIX_LAST) begin
          rd_pix_reg <= '0;
          rd_sel_reg <= rd_sel_reg + 2'd1;
        end else begin
          rd_pix_reg <= rd_pix_reg + PIX_ONE;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Window addressing: right edge replicated for columns 1 and 2.
  // -------------------------------------------------------------------------
  always_comb begin
    col_idx[0] = rd_pix_reg;
    col_idx[1] = (rd_pix_reg == PIX_LAST) ? PIX_LAST : rd_pix_reg + PIX_ONE;
    col_idx[2] = (rd_pix_reg >= PIX_LAST - PIX_ONE) ? PIX_LAST : rd_pix_reg + PIX_TWO;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_row
      assign row_idx[gi] = rd_sel_reg + 2'(gi);
    end
    for (gi = 0; gi < 9; gi++) begin : g_tap
      assign window_next[gi*DATA_W +: DATA_W] = lb[row_idx[gi/3]][col_idx[gi%3]];
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Registered outputs. The buffers are sampled before this edge's write
  // lands, so a same-address write returns the old pixel.
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_pixel_data       <= '0;
      o_pixel_data_valid <= 1'b0;
      o_intr             <= 1'b0;
    end else begin
      o_pixel_data_valid <= rd_en;
      o_intr             <= rd_en && (rd_pix_reg == PIX_LAST);
      if (rd_en) begin
        o_pixel_data <= window_next;
      end
    end
  end

endmodule
